// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   MEM pipeline stage sitting between the EX/MEM and MEM/WB registers.
//   Converts a load/store from EX/MEM into one req/ack transaction on the
//   data-memory bus, aligns byte/half/word accesses onto the 32-bit bus,
//   and returns sign- or zero-extended load data. Upstream stages are frozen
//   through stall_out while the bus transaction is outstanding.
//
// Ports
//   clk, reset        clock (posedge) / asynchronous active-low reset
//   start             pipeline enable, access accepted only when high
//   mem_read_in       load request
//   mem_write_in      store request (has priority over mem_read_in)
//   inst_in           instruction word, funct3 = inst_in[14:12]
//   result_in         effective byte address
//   rd23_in           store data (rs2)
//   dmem_*            data-memory bus (see handshake below)
//   stall_out         combinational upstream freeze
//   load_valid        one-cycle pulse, load_data holds the new result
//   load_data         extended load result, held until the next load_valid
//   misaligned        one-cycle pulse, access rejected without a bus cycle
//   bus_err           one-cycle pulse, no dmem_ack within TIMEOUT cycles
//   state_dbg         current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Bus handshake
//   dmem_req rises the cycle after an aligned access is accepted and stays
//   high, with dmem_we/addr/be/wdata stable, until the memory returns a
//   single-cycle dmem_ack (dmem_rdata valid in that same cycle) or the wait
//   counter reaches TIMEOUT. dmem_req is low the cycle after either event.
//   dmem_ack outside a pending request is ignored.
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rd23_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic [2:0]  f3;
    logic [1:0]  off;
    size_t       acc_size;
    logic        is_misaligned;
    logic        accept;
    logic        timeout_hit;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    assign f3  = inst_in[14:12];
    assign off = result_in[1:0];

    // Unsigned byte/half encodings only exist for loads; for stores they
    // fall into the undefined group, which behaves as a full word.
    always_comb begin
        acc_size = SZ_W;
        if (f3 == 3'b000 || (!mem_write_in && f3 == 3'b100)) begin
            acc_size = SZ_B;
        end else if (f3 == 3'b001 || (!mem_write_in && f3 == 3'b101)) begin
            acc_size = SZ_H;
        end
    end

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = rd23_in;
        case (acc_size)
            SZ_B: begin
                be_new    = 4'b0001 << off;
                wdata_new = {4{rd23_in[7:0]}};
            end
            SZ_H: begin
                be_new    = 4'b0011 << off;
                wdata_new = {2{rd23_in[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = rd23_in;
            end
        endcase
    end

    assign is_misaligned = (acc_size == SZ_H && off[0]) ||
                           (acc_size == SZ_W && off != 2'b00);
    assign accept        = (state == S_IDLE) && start && (mem_read_in || mem_write_in);
    assign timeout_hit   = (cnt == TIMEOUT_CNT);
    assign stall_out     = (accept && !is_misaligned) || (state == S_BUSY);
    assign state_dbg     = state;

    function automatic logic [31:0] extend_load(input logic [31:0] rd,
                                                input logic [2:0]  fn,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (fn)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b100:  extend_load = {24'd0, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b101:  extend_load = {16'd0, h};
            default: extend_load = rd;
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept && !is_misaligned) state_next = S_BUSY;
            S_BUSY: begin
                if (dmem_ack)         state_next = S_DONE;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus outputs, latched request fields, wait counter and result pulses.
    // The load result is extended at ack time so DONE only has to pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
            load_valid <= 1'b0;
            load_data  <= 32'd0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            cnt        <= 8'd0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
        end else begin
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_misaligned) begin
                            misaligned <= 1'b1;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write_in;
                            dmem_addr  <= {result_in[31:2], 2'b00};
                            dmem_wdata <= wdata_new;
                            dmem_be    <= be_new;
                            f3_q       <= f3;
                            off_q      <= off;
                            cnt        <= 8'd1;
                        end
                    end
                end
                S_BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (!dmem_we) begin
                            load_valid <= 1'b1;
                            load_data  <= extend_load(dmem_rdata, f3_q, off_q);
                        end
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        bus_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] inst_in;
    logic [31:0] result_in;
    logic [31:0] rd23_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_out;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic        bus_err;
    logic [1:0]  state_dbg;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_load = 32'd0;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .inst_in      (inst_in),
        .result_in    (result_in),
        .rd23_in      (rd23_in),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall_out    (stall_out),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .bus_err      (bus_err),
        .state_dbg    (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input bit w, input logic [2:0] fn);
        if (fn == 3'd0 || (!w && fn == 3'd4)) return 1;
        if (fn == 3'd1 || (!w && fn == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input int n, input int off);
        logic [31:0] t;
        t = ((32'd1 << n) - 32'd1) << off;
        return t[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int n, input logic [31:0] d);
        if (n == 1) return {24'd0, d[7:0]} * 32'h01010101;
        if (n == 2) return {16'd0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] fn, input int off,
                                               input logic [31:0] rd);
        int          n;
        logic [31:0] mask;
        logic [31:0] v;
        n = acc_bytes(1'b0, fn);
        if (n == 4) return rd;
        mask = (n == 1) ? 32'h000000FF : 32'h0000FFFF;
        v = (rd >> (8 * off)) & mask;
        if ((fn == 3'd0 || fn == 3'd1) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver ----------------
    // dly < TIMEOUT: ack in BUSY cycle dly; otherwise the ack is withheld.
    task automatic do_access(input bit w, input logic [2:0] fn, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rd, input int dly);
        int          n;
        int          off;
        bit          mis;
        bit          acked;
        logic [31:0] inst;
        n     = acc_bytes(w, fn);
        off   = int'(a[1:0]);
        mis   = (off % n) != 0;
        acked = 1'b0;
        inst  = $urandom;
        inst[14:12] = fn;

        @(negedge clk);
        dmem_ack     = 1'b0;
        start        = 1'b1;
        mem_write_in = w;
        mem_read_in  = w ? 1'($urandom_range(0, 1)) : 1'b1;
        inst_in      = inst;
        result_in    = a;
        rd23_in      = d;
        #1;
        check("stall_at_accept", {31'd0, stall_out}, {31'd0, !mis});
        check("req_idle", {31'd0, dmem_req}, 32'd0);

        @(negedge clk);
        start        = 1'($urandom_range(0, 1));
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        if (mis) begin
            #1;
            check("misaligned_pulse", {31'd0, misaligned}, 32'd1);
            check("misaligned_no_req", {31'd0, dmem_req}, 32'd0);
            check("misaligned_no_stall", {31'd0, stall_out}, 32'd0);
            @(negedge clk);
            #1;
            check("misaligned_clear", {31'd0, misaligned}, 32'd0);
            check("misaligned_no_req2", {31'd0, dmem_req}, 32'd0);
            return;
        end

        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            check("busy_req", {31'd0, dmem_req}, 32'd1);
            check("busy_we", {31'd0, dmem_we}, {31'd0, w});
            check("busy_addr", dmem_addr, {a[31:2], 2'b00});
            check("busy_be", {28'd0, dmem_be}, {28'd0, model_be(n, off)});
            if (w) check("busy_wdata", dmem_wdata, model_wdata(n, d));
            check("busy_stall", {31'd0, stall_out}, 32'd1);
            if (i == dly) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rd;
                if (!w) exp_q.push_back(model_load(fn, off, rd));
            end
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (i == dly) begin
                acked = 1'b1;
                break;
            end
        end

        // DONE cycle (or first cycle after a timeout); a stray ack here is ignored
        dmem_ack = 1'($urandom_range(0, 1));
        #1;
        check("after_req", {31'd0, dmem_req}, 32'd0);
        check("after_stall", {31'd0, stall_out}, 32'd0);
        if (acked) begin
            check("load_valid", {31'd0, load_valid}, {31'd0, !w});
            check("no_bus_err", {31'd0, bus_err}, 32'd0);
            if (!w && exp_q.size() > 0) exp_load = exp_q.pop_front();
        end else begin
            check("bus_err_pulse", {31'd0, bus_err}, 32'd1);
            check("timeout_no_valid", {31'd0, load_valid}, 32'd0);
        end
        check("load_data", load_data, exp_load);

        @(negedge clk);
        dmem_ack = 1'($urandom_range(0, 1));
        #1;
        check("idle_valid_clear", {31'd0, load_valid}, 32'd0);
        check("idle_err_clear", {31'd0, bus_err}, 32'd0);
        check("idle_req", {31'd0, dmem_req}, 32'd0);
        check("idle_stall", {31'd0, stall_out}, 32'd0);
        check("load_data_held", load_data, exp_load);
    endtask

    task automatic reset_mid_access();
        @(negedge clk);
        dmem_ack     = 1'b0;
        start        = 1'b1;
        mem_read_in  = 1'b1;
        mem_write_in = 1'b0;
        inst_in      = 32'h00002003;
        result_in    = 32'h00000200;
        @(negedge clk);
        start       = 1'b0;
        mem_read_in = 1'b0;
        #1;
        check("rst_busy_req", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_req_drop", {31'd0, dmem_req}, 32'd0);
        check("rst_stall_drop", {31'd0, stall_out}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_load = 32'd0;
        exp_q.delete();
        #1;
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        #1;
        check("rst_after_req", {31'd0, dmem_req}, 32'd0);
        check("rst_after_valid", {31'd0, load_valid}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        inst_in      = 32'd0;
        result_in    = 32'd0;
        rd23_in      = 32'd0;
        dmem_rdata   = 32'd0;
        dmem_ack     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req", {31'd0, dmem_req}, 32'd0);
        check("reset_addr", dmem_addr, 32'd0);
        check("reset_be", {28'd0, dmem_be}, 32'd0);
        check("reset_load_data", load_data, 32'd0);
        check("reset_pulses", {29'd0, load_valid, misaligned, bus_err}, 32'd0);
        reset = 1'b1;

        // directed cases
        do_access(1'b0, 3'b010, 32'h00000100, 32'd0, 32'hDEADBEEF, 0);
        check("lw_result", load_data, 32'hDEADBEEF);
        do_access(1'b0, 3'b000, 32'h00000103, 32'd0, 32'h80123456, 0);
        check("lb_result", load_data, 32'hFFFFFF80);
        do_access(1'b0, 3'b100, 32'h00000103, 32'd0, 32'h80123456, 1);
        check("lbu_result", load_data, 32'h00000080);
        do_access(1'b1, 3'b001, 32'h00000102, 32'h1234ABCD, 32'd0, 0);
        check("sh_no_load_change", load_data, 32'h00000080);
        do_access(1'b0, 3'b001, 32'h00000101, 32'd0, 32'd0, 0);
        do_access(1'b0, 3'b010, 32'h00000104, 32'd0, 32'h11111111, TIMEOUT + 3);
        check("timeout_data_kept", load_data, 32'h00000080);
        do_access(1'b0, 3'b101, 32'h00000102, 32'd0, 32'h8765FFFF, TIMEOUT - 1);
        check("lhu_last_cycle_ack", load_data, 32'h00008765);
        reset_mid_access();

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom, $urandom_range(0, TIMEOUT + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
